// File: rtl/fencei_seq_pkg.sv
// Shared definitions for the FENCE.I sequencer: state encoding and default widths/offsets.
package fencei_seq_pkg;

    localparam logic [2:0] FS_IDLE   = 3'd0;
    localparam logic [2:0] FS_DRAIN  = 3'd1;
    localparam logic [2:0] FS_DFLUSH = 3'd2;
    localparam logic [2:0] FS_IINVAL = 3'd3;
    localparam logic [2:0] FS_REDIR  = 3'd4;

    localparam int unsigned PC_W       = 64;
    localparam int unsigned PC_INC_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = FS_IDLE,
        ST_DRAIN  = FS_DRAIN,
        ST_DFLUSH = FS_DFLUSH,
        ST_IINVAL = FS_IINVAL,
        ST_REDIR  = FS_REDIR
    } fs_state_e;

endpackage

// File: rtl/fencei_seq_if.sv
// Signal bundle between issue/decode, the caches, fetch and the FENCE.I sequencer.
interface fencei_seq_if #(
    parameter int unsigned CNT_W = fencei_seq_pkg::CNT_W_DEF
);
    logic                              pipe_flush;
    logic                              req_valid;
    logic [fencei_seq_pkg::PC_W-1:0]   req_pc;
    logic                              req_done;
    logic                              busy;
    logic                              pipes_idle;
    logic                              dm_flush_req;
    logic                              dm_flush_resp;
    logic                              im_invalidate_req;
    logic                              im_invalidate_resp;
    logic                              ix_if_pc_override;
    logic [fencei_seq_pkg::PC_W-1:0]   ix_if_new_pc;
    logic [CNT_W-1:0]                  last_latency;

    modport slave (
        input  pipe_flush, req_valid, req_pc, pipes_idle, dm_flush_resp, im_invalidate_resp,
        output req_done, busy, dm_flush_req, im_invalidate_req, ix_if_pc_override,
               ix_if_new_pc, last_latency
    );

    modport master (
        output pipe_flush, req_valid, req_pc, pipes_idle, dm_flush_resp, im_invalidate_resp,
        input  req_done, busy, dm_flush_req, im_invalidate_req, ix_if_pc_override,
               ix_if_new_pc, last_latency
    );
endinterface

// File: rtl/fencei_seq.sv
// FENCE.I sequencer: drain pipes, flush D$, invalidate I$, then redirect fetch past the fence.
module fencei_seq
    import fencei_seq_pkg::*;
#(
    parameter int unsigned PC_INC = PC_INC_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fencei_seq_if.slave   bus_io
);

    fs_state_e         state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   new_pc_q, new_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              aborted_q, aborted_d;
    logic              dm_req_q, dm_req_d;
    logic              im_req_q, im_req_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            new_pc_q  <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            aborted_q <= 1'b0;
            dm_req_q  <= 1'b0;
            im_req_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            new_pc_q  <= new_pc_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            aborted_q <= aborted_d;
            dm_req_q  <= dm_req_d;
            im_req_q  <= im_req_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic; counter holds cycles elapsed since accept
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        new_pc_d  = '0;
        cnt_d     = (state_q == ST_IDLE) ? cnt_q : cnt_inc;
        lat_d     = lat_q;
        aborted_d = aborted_q;
        dm_req_d  = dm_req_q;
        im_req_d  = im_req_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                aborted_d = 1'b0;
                if (bus_io.req_valid && !bus_io.pipe_flush) begin
                    pc_d    = bus_io.req_pc;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus_io.pipe_flush || !bus_io.req_valid) begin
                    state_d = ST_IDLE;
                end else if (bus_io.pipes_idle) begin
                    dm_req_d = 1'b1;
                    state_d  = ST_DFLUSH;
                end
            end
            ST_DFLUSH: begin
                if (bus_io.pipe_flush) aborted_d = 1'b1;
                if (bus_io.dm_flush_resp) begin
                    dm_req_d = 1'b0;
                    im_req_d = 1'b1;
                    state_d  = ST_IINVAL;
                end
            end
            ST_IINVAL: begin
                if (bus_io.pipe_flush) aborted_d = 1'b1;
                if (bus_io.im_invalidate_resp) begin
                    im_req_d = 1'b0;
                    // A flush in the exit cycle itself also suppresses the redirect
                    if (aborted_q || bus_io.pipe_flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_REDIR;
                        done_d   = 1'b1;
                        new_pc_d = pc_q + PC_W'(PC_INC);
                        lat_d    = cnt_inc;
                    end
                end
            end
            ST_REDIR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus_io.req_done          = done_q;
    assign bus_io.ix_if_pc_override = done_q;
    assign bus_io.ix_if_new_pc      = new_pc_q;
    assign bus_io.busy              = busy_q;
    assign bus_io.dm_flush_req      = dm_req_q;
    assign bus_io.im_invalidate_req = im_req_q;
    assign bus_io.last_latency      = lat_q;

endmodule

// File: tb/tb_fencei_seq.sv
// Self-checking bench for fencei_seq: each fence's output windows are derived in closed form from its delays.
module tb_fencei_seq;
    import fencei_seq_pkg::*;

    localparam int unsigned CW     = 4;
    localparam int unsigned LATMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fencei_seq_if #(.CNT_W(CW)) bus ();

    fencei_seq #(.PC_INC(4), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_lat;

    task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // d: DRAIN cycles with pipes busy; a/b: extra cycles before each cache response;
    // f: cycle of a pipe_flush pulse (-1 none); r: cycle of a reset pulse (-1 none).
    task automatic run_fence(input logic [63:0] pc, input int d, input int a, input int b,
                             input int f, input int r);
        int  n, dm_lo, dm_hi, im_lo, im_hi, last, req_end, stop;
        bit  drain_ab, cache_ab, rst_hit, normal;
        n        = 4 + d + a + b;
        dm_lo    = 2 + d;
        dm_hi    = 2 + d + a;
        im_lo    = 3 + d + a;
        im_hi    = 3 + d + a + b;
        drain_ab = (f >= 1) && (f <= 1 + d);
        cache_ab = (f >= dm_lo) && (f <= im_hi);
        rst_hit  = (r >= 0);
        normal   = !drain_ab && !cache_ab && !rst_hit;
        last     = drain_ab ? f : (cache_ab ? im_hi : n);
        req_end  = normal ? n : (rst_hit ? r : f);
        stop     = (rst_hit ? r : last) + 2;
        for (int c = 0; c <= stop; c++) begin
            bit live;
            live = !rst_hit || (c <= r);
            rst                    = rst_hit && (c == r);
            bus.req_valid          = (c <= req_end);
            bus.req_pc             = (c == 0) ? pc : {$urandom, $urandom};
            bus.pipe_flush         = (c == f);
            bus.pipes_idle         = in_rng(c, 1, d) ? 1'b0 :
                                     (c == 1 + d) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.dm_flush_resp      = (c == dm_hi) ? 1'b1 :
                                     in_rng(c, dm_lo, dm_hi) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.im_invalidate_resp = (c == im_hi) ? 1'b1 :
                                     in_rng(c, im_lo, im_hi) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("busy", c, 64'(bus.busy), 64'(live && in_rng(c, 1, last)));
            chk("dm_flush_req", c, 64'(bus.dm_flush_req), 64'(live && !drain_ab && in_rng(c, dm_lo, dm_hi)));
            chk("im_invalidate_req", c, 64'(bus.im_invalidate_req),
                64'(live && !drain_ab && in_rng(c, im_lo, im_hi)));
            chk("req_done", c, 64'(bus.req_done), 64'(live && normal && (c == n)));
            chk("pc_override", c, 64'(bus.ix_if_pc_override), 64'(live && normal && (c == n)));
            if (live && normal && (c == n)) chk("new_pc", c, bus.ix_if_new_pc, pc + 64'd4);
            if (rst_hit && (c == r + 1)) chk("new_pc_after_rst", c, bus.ix_if_new_pc, 64'd0);
            @(posedge clk);
            #1;
        end
        if (rst_hit) exp_lat = '0;
        else if (normal) exp_lat = (n > int'(LATMAX)) ? CW'(LATMAX) : CW'(n);
        chk("last_latency", stop, 64'(bus.last_latency), 64'(exp_lat));
        rst                    = 1'b0;
        bus.req_valid          = 1'b0;
        bus.pipe_flush         = 1'b0;
        bus.dm_flush_resp      = 1'b0;
        bus.im_invalidate_resp = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        bus.pipe_flush         = 1'b0;
        bus.req_valid          = 1'b1;
        bus.req_pc             = 64'h1234;
        bus.pipes_idle         = 1'b1;
        bus.dm_flush_resp      = 1'b1;
        bus.im_invalidate_resp = 1'b1;
        exp_lat                = '0;
        repeat (3) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", 0, 64'(bus.busy), 64'd0);
        chk("rst_dm_req", 0, 64'(bus.dm_flush_req), 64'd0);
        chk("rst_im_req", 0, 64'(bus.im_invalidate_req), 64'd0);
        chk("rst_done", 0, 64'(bus.req_done), 64'd0);
        chk("rst_override", 0, 64'(bus.ix_if_pc_override), 64'd0);
        chk("rst_new_pc", 0, bus.ix_if_new_pc, 64'd0);
        chk("rst_latency", 0, 64'(bus.last_latency), 64'd0);
        @(posedge clk);
        #1;

        // Minimum latency with idle pipes and immediate responses
        run_fence(64'h0000_0000_8000_0100, 0, 0, 0, -1, -1);
        // Drain wait and delayed D$ response
        run_fence(64'h0000_0000_4000_0020, 5, 3, 1, -1, -1);
        // Flush while draining
        run_fence(64'h0000_0000_1000_0000, 3, 1, 1, 2, -1);
        // Flush during the D$ flush phase
        run_fence(64'h0000_0000_2000_0040, 1, 4, 2, 4, -1);
        // Flush in the IINVAL exit cycle
        run_fence(64'h0000_0000_2000_0080, 0, 1, 2, 6, -1);
        // PC wrap; stray responses in IDLE are randomised inside run_fence
        run_fence(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, -1, -1);
        // Reset mid-IINVAL, then a normal fence
        run_fence(64'h0000_0000_3000_0000, 0, 0, 5, -1, 5);
        run_fence(64'h0000_0000_3000_0010, 1, 1, 1, -1, -1);
        // Latency counter saturation
        run_fence(64'h0000_0000_5000_0000, 6, 5, 5, -1, -1);

        for (int i = 0; i < 24; i++) begin
            int d, a, b, kind, f;
            logic [63:0] pc;
            d    = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 3));
            b    = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            pc   = {$urandom, $urandom};
            if (kind == 2)      f = 1 + int'($urandom_range(0, d));
            else if (kind == 3) f = 2 + d + int'($urandom_range(0, a + b + 1));
            else                f = -1;
            run_fence(pc, d, a, b, f, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fencei_seq.md
# fencei_seq

Sequencer for FENCE.I, sitting beside the issue stage. It takes a legal FENCE.I presented by decode and waits for both execution pipes to drain. It then flushes the data cache, invalidates the instruction cache, and redirects fetch to the instruction following the fence. Data-cache flush is strictly ordered before instruction-cache invalidation, so refetched code always observes written-back stores.

## Interface
Parameters:
- `PC_INC`, default 4: byte offset added to the fence PC to form the redirect target.
- `CNT_W`, default 16: width of the saturating latency counter.

Ports (clock and reset first):
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `pipe_flush` in 1: pipeline flush from the branch/trap path.
- `req_valid` in 1: decode presents a legal FENCE.I. Held until `req_done`.
- `req_pc` in 64: PC of the fence.
- `req_done` out 1: single-cycle pulse; the issue stage retires the fence.
- `busy` out 1: high whenever state is not IDLE.
- `pipes_idle` in 1: no instruction is in flight in the integer pipe or the load/store pipe.
- `dm_flush_req` out 1: data-cache flush request.
- `dm_flush_resp` in 1: data-cache flush complete.
- `im_invalidate_req` out 1: instruction-cache invalidate request.
- `im_invalidate_resp` in 1: instruction-cache invalidate complete.
- `ix_if_pc_override` out 1: fetch redirect strobe.
- `ix_if_new_pc` out 64: fetch redirect target.
- `last_latency` out `CNT_W`: cycles from accept to `req_done` for the last completed fence. Saturates at all-ones.

## Operation
- **States:** IDLE, DRAIN, DFLUSH, IINVAL, REDIR. All outputs are registered.
- **IDLE:** on `req_valid && !pipe_flush`, latch `req_pc`, clear the counter, go to DRAIN.
- **DRAIN:**
  - `pipe_flush` or `!req_valid` → IDLE with no side effects.
  - Otherwise, when `pipes_idle`, set `dm_flush_req` and go to DFLUSH.
- **DFLUSH:** hold `dm_flush_req` until `dm_flush_resp` is sampled high. Then clear `dm_flush_req`, set `im_invalidate_req`, go to IINVAL.
- **IINVAL:** hold `im_invalidate_req` until `im_invalidate_resp` is sampled high. Then clear it and go to REDIR, driving:
  - `ix_if_pc_override` = 1
  - `ix_if_new_pc` = latched PC + `PC_INC` (64-bit, wraps modulo 2^64)
  - `req_done` = 1
  - `last_latency` = counter
- **REDIR:** outputs pulse for exactly one cycle. Clear them and go to IDLE.
- **Flush during a cache phase:** a cache request already issued is never withdrawn. A `pipe_flush` seen in DFLUSH or IINVAL sets a sticky `aborted` flag.
  - Sequencing still completes both cache operations.
  - On exit from IINVAL the block goes to IDLE instead of REDIR; no override, no `req_done`, `last_latency` unchanged.
- **Stray responses:** `dm_flush_resp` or `im_invalidate_resp` arriving in any other state is ignored.
- **Counter:** increments every cycle the block is not IDLE, saturating at all-ones.
- **`busy`:** may be used by issue to hold off the next instruction.

## Timing
- **Reset values:** all outputs 0, `ix_if_new_pc` = 0, state IDLE, `aborted` = 0, counter 0. Reset in any state aborts immediately; cache requests drop the cycle after reset.
- **Minimum latency**, with `pipes_idle` and both responses combinationally high:
  - `req_valid` accepted in cycle 0, DRAIN in cycle 1.
  - `dm_flush_req` high in cycle 2.
  - `im_invalidate_req` high in cycle 3.
  - `req_done` / override in cycle 4.
- **Request handshake:** each request rises no earlier than the cycle after the state entry and stays high until the response is sampled. It falls the cycle after.
- **Exclusivity:** `dm_flush_req` and `im_invalidate_req` are never high in the same cycle.
- **Back-to-back fences:** a new request is accepted in IDLE only, i.e. no earlier than one cycle after REDIR.
- **`req_done` timing:** `req_done` and `ix_if_pc_override` are coincident.

## Structure
- A shared package holds:
  - the state encoding as localparams `FS_IDLE`..`FS_REDIR`;
  - the `PC_INC` default.
- Single flat module. No sub-module; the FSM plus counter is small.
- The issue stage removes its inline FENCE.I logic and instantiates this block.

## Test plan
- **Idle pipes, immediate responses:** `req_pc` = 0x8000_0100 → override with `new_pc` = 0x8000_0104 at cycle 4, `last_latency` = 4.
- **Drain wait:** `pipes_idle` low for 5 cycles, `dm_flush_resp` delayed 3 cycles → `dm_flush_req` rises only after `pipes_idle`. `im_invalidate_req` rises the cycle after `dm_flush_resp` is sampled, never overlapping `dm_flush_req`.
- **Flush in DRAIN:** `pipe_flush` in DRAIN → IDLE next cycle; no cache requests, no override.
- **Flush in DFLUSH:** `pipe_flush` in DFLUSH → both cache operations complete; no `req_done`, no override; `busy` drops after `im_invalidate_resp`.
- **Wrap and stray response:** `req_pc` = 0xFFFF_FFFF_FFFF_FFFC → `new_pc` = 0. A stray `im_invalidate_resp` pulse in IDLE has no effect.
- **Reset mid-IINVAL:** `rst` asserted during IINVAL → all outputs 0 the next cycle. A subsequent fence runs normally.
